// File: rtl/sw_diff_pkg.sv
// Shared types and constants for the difference-score decoder.
// Delta legality helper is kept here so producers and consumers agree on it.
package sw_diff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DELTA_W   = 4;
  localparam int DELTA_MIN = -6;
  localparam int DELTA_MAX = 7;

  // -8 and -7 are encodable in 4 bits but never produced by the cell array
  function automatic logic is_illegal_delta(input logic [DELTA_W-1:0] d);
    return ($signed(d) < DELTA_MIN);
  endfunction

endpackage

// File: rtl/sw_diff_sat_add.sv
// Signed add of a sign-extended delta onto a SCORE_W accumulator.
// Purely combinational; clamps to the SCORE_W range and flags the clamp.
module sw_diff_sat_add
  import sw_diff_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic [SCORE_W-1:0] acc,
  input  logic [DELTA_W-1:0] delta,
  output logic [SCORE_W-1:0] sum,
  output logic               sat
);

  logic [SCORE_W:0] wide;

  always_comb begin
    wide = {acc[SCORE_W-1], acc} + {{(SCORE_W+1-DELTA_W){delta[DELTA_W-1]}}, delta};
    sat  = (wide[SCORE_W] != wide[SCORE_W-1]);
    sum  = wide[SCORE_W-1:0];
    // the extra top bit holds the true sign and picks the clamp direction
    if (sat) begin
      sum = wide[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sw_diff_decoder.sv
// Rebuilds absolute Smith-Waterman scores from a signed delta stream, one score/cycle, 1-cycle latency.
// Single output register with pass-through ready; optional row-max tracking under SW_DIFF_DECODER_MAXTRACK_EN.
module sw_diff_decoder
  import sw_diff_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int COL_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] anchor,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DELTA_W-1:0] in_delta,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_score,
  output logic [COL_W-1:0]   out_col,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] max_score,
  output logic [COL_W-1:0]   max_col,
  output logic               ovf,
  output logic               err
);

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] sum;
  logic               sat;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_nxt;
  logic               col_full;
  logic               accept;
  logic               handoff;
  logic               row_load;

  sw_diff_sat_add #(.SCORE_W(SCORE_W)) u_add (
    .acc   (acc),
    .delta (in_delta),
    .sum   (sum),
    .sat   (sat)
  );

  assign col_full = &col;
  assign col_nxt  = col_full ? col : col + 1'b1;
  assign handoff  = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign row_load = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_valid && out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (row_load) begin
        acc <= anchor;
        col <= '0;
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (accept) begin
        acc       <= sum;
        col       <= col_nxt;
        out_score <= sum;
        out_col   <= col_nxt;
        out_last  <= in_last;
        out_valid <= 1'b1;
        ovf       <= ovf | sat | col_full;
        // illegal deltas are still accumulated at face value
        err       <= err | is_illegal_delta(in_delta);
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SW_DIFF_DECODER_MAXTRACK_EN
  logic [SCORE_W-1:0] max_q;
  logic [COL_W-1:0]   max_col_q;

  // strict compare keeps the first column on ties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q     <= '0;
      max_col_q <= '0;
    end else if (row_load) begin
      max_q     <= anchor;
      max_col_q <= '0;
    end else if (accept && ($signed(sum) > $signed(max_q))) begin
      max_q     <= sum;
      max_col_q <= col_nxt;
    end
  end

  assign max_score = max_q;
  assign max_col   = max_col_q;
`else
  assign max_score = '0;
  assign max_col   = '0;
`endif

endmodule

// File: tb/tb_sw_diff_decoder.sv
// Directed scoreboard bench for sw_diff_decoder (SCORE_W=16, COL_W=10).
module tb_sw_diff_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] anchor = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_delta = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_score;
  logic [9:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] max_score;
  logic [9:0]  max_col;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic toggle_en = 1'b0;

  typedef struct {
    logic [15:0] score;
    logic [9:0]  col;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  sw_diff_decoder #(.SCORE_W(16), .COL_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .anchor(anchor),
    .in_valid(in_valid), .in_ready(in_ready), .in_delta(in_delta), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score),
    .out_col(out_col), .out_last(out_last), .busy(busy), .done(done),
    .max_score(max_score), .max_col(max_col), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) out_ready = ~out_ready;
    end
  end

  // monitor: pops the scoreboard on every output hand-off
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got score=%0d col=%0d, required no output",
                   $signed(out_score), out_col);
        end else begin
          e = exp_q.pop_front();
          if (out_score !== e.score || out_col !== e.col || out_last !== e.last) begin
            errors++;
            $display("FAIL output: got score=%0d col=%0d last=%0b, required score=%0d col=%0d last=%0b",
                     $signed(out_score), out_col, out_last, $signed(e.score), e.col, e.last);
          end
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %0b, required 0", in_ready);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_score"}, {16'd0, out_score}, 0);
    chk({tag, "_out_col"}, {22'd0, out_col}, 0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_max_score"}, {16'd0, max_score}, 0);
    chk({tag, "_max_col"}, {22'd0, max_col}, 0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
  endtask

  task automatic start_row(input logic [15:0] a);
    start  = 1'b1;
    anchor = a;
    tick();
    start  = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic l, input logic [15:0] es, input logic [9:0] ec);
    int   n;
    logic ok;
    exp_q.push_back('{score: es, col: ec, last: l});
    in_valid = 1'b1;
    in_delta = d;
    in_last  = l;
    n = 0;
    do begin
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready in %0d cycles, required acceptance", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic chk_max(input string tag, input logic [15:0] ms, input logic [9:0] mc);
`ifdef SW_DIFF_DECODER_MAXTRACK_EN
    chk({tag, "_max_score"}, {16'd0, max_score}, {16'd0, ms});
    chk({tag, "_max_col"}, {22'd0, max_col}, {22'd0, mc});
`else
    chk({tag, "_max_score"}, {16'd0, max_score}, 0);
    chk({tag, "_max_col"}, {22'd0, max_col}, 0);
`endif
  endtask

  initial begin
    repeat (3) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // basic row, out_ready held high
    start_row(16'd10);
    chk("run_busy", {31'd0, busy}, 1);
    send(4'd3, 1'b0, 16'd13, 10'd1);
    send(4'hE, 1'b0, 16'd11, 10'd2);
    send(4'd7, 1'b0, 16'd18, 10'd3);
    send(4'hA, 1'b1, 16'd12, 10'd4);
    wait_idle();
    chk("row1_done_cnt", done_cnt, 1);
    chk_max("row1", 16'd18, 10'd3);
    chk("row1_ovf", {31'd0, ovf}, 0);
    chk("row1_err", {31'd0, err}, 0);

    // same row under toggling backpressure
    toggle_en = 1'b1;
    start_row(16'd10);
    send(4'd3, 1'b0, 16'd13, 10'd1);
    send(4'hE, 1'b0, 16'd11, 10'd2);
    send(4'd7, 1'b0, 16'd18, 10'd3);
    send(4'hA, 1'b1, 16'd12, 10'd4);
    wait_idle();
    toggle_en = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("row2_done_cnt", done_cnt, 2);
    chk_max("row2", 16'd18, 10'd3);

    // positive and negative saturation
    start_row(16'd32765);
    send(4'd7, 1'b1, 16'h7FFF, 10'd1);
    wait_idle();
    chk("satpos_ovf", {31'd0, ovf}, 1);
    start_row(16'h8002);
    send(4'hA, 1'b1, 16'h8000, 10'd1);
    wait_idle();
    chk("satneg_ovf", {31'd0, ovf}, 1);

    // illegal delta accumulated at face value; ovf cleared by start
    start_row(16'd0);
    send(4'b1000, 1'b1, 16'hFFF8, 10'd1);
    wait_idle();
    chk("illegal_err", {31'd0, err}, 1);
    chk("illegal_ovf", {31'd0, ovf}, 0);
    chk_max("illegal", 16'd0, 10'd0);

    // reset mid-row discards the partial row
    start_row(16'd10);
    send(4'd3, 1'b0, 16'd13, 10'd1);
    send(4'hE, 1'b0, 16'd11, 10'd2);
    rst_n = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    tick();
    start_row(16'd5);
    send(4'd1, 1'b1, 16'd6, 10'd1);
    wait_idle();

    // start during RUN ignored; tied maxima keep the first column
    start_row(16'd0);
    send(4'd2, 1'b0, 16'd2, 10'd1);
    send(4'd3, 1'b0, 16'd5, 10'd2);
    start_row(16'd100);
    send(4'hD, 1'b0, 16'd2, 10'd3);
    send(4'd3, 1'b0, 16'd5, 10'd4);
    send(4'hE, 1'b1, 16'd3, 10'd5);
    wait_idle();
    chk_max("tie", 16'd5, 10'd2);

    // column counter saturation
    start_row(16'd0);
    for (int i = 1; i <= 1023; i++) send(4'd0, 1'b0, 16'd0, i[9:0]);
    chk("col_edge_ovf", {31'd0, ovf}, 0);
    send(4'd0, 1'b1, 16'd0, 10'd1023);
    wait_idle();
    chk("col_sat_ovf", {31'd0, ovf}, 1);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
